forwarding_hazard_unit: RTL and testbench
=========================================

Name: forwarding_hazard_unit

Overview:
Parametrised successor to the pipeline's operand-forwarding logic. It tracks STAGES in-flight writers in an internal shift pipeline and produces a forwarding select per source operand, with the youngest matching producer winning. It detects load-use hazards and stalls issue until load data reaches LOAD_STAGE, and it counts stall cycles. It sits at the decode/issue boundary and drives the operand muxes in front of the execute stage.

Parameters:
REG_ADDR_W, 3, register address width.
STAGES, 3, number of tracked in-flight stages; legal range 1..7.
LOAD_STAGE, 2, first stage at which LOAD data can be forwarded; legal range 1..STAGES.
CNT_W, 16, width of the stall counter.
SEL_W (localparam), clog2(STAGES+1), width of each forwarding select.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  reset; synchronous and active-low.
flush  in  1  clears all tracked entries; discards the instruction presented this cycle.
issue_valid  in  1  an instruction is presented on opcode/source_1/source_2/destination/write_en.
issue_ready  out  1  the presented instruction is accepted this cycle.
opcode  in  7  opcode of the presented instruction; uses the existing `OPCODE_* field macros.
source_1  in  REG_ADDR_W  first source register.
source_2  in  REG_ADDR_W  second source register.
destination  in  REG_ADDR_W  destination register.
write_en  in  1  the presented instruction writes destination.
fwd1_sel  out  SEL_W  source_1 operand select: 0 = register file, k = stage k result.
fwd2_sel  out  SEL_W  source_2 operand select, same encoding as fwd1_sel.
stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Tracker: entries e[1..STAGES]. Each entry holds {valid, dest, wr, is_load}. e[1] is the instruction issued in the previous cycle.
- Every cycle, e[k+1] <= e[k] for k = 1..STAGES-1. The oldest entry, e[STAGES], drops out.
- e[1] <= the presented instruction when issue_valid & issue_ready & !flush. Otherwise e[1] <= bubble (valid=0).
- Operand usage comes from operand_usage_decode (combinational).
  - use1 is set for arithmetic (ADD/ADDF/SUB/SUBF), logic (AND/OR/XOR/NAND/NOR/NXOR), shift (SHIFTR/SHIFTRA/SHIFTL), LOADC, STORE, JMPcond and JMPRcond.
  - use2 is set for arithmetic, logic, LOAD, STORE, JMP and JMPcond.
  - is_load = (opcode == LOAD). Undefined opcodes: use1 = use2 = 0.
- Match for source n at stage k: useN & e[k].valid & e[k].wr & (e[k].dest == source_n).
- fwdN_sel = the smallest k that matches, else 0. The selects are combinational from the current inputs and tracker state (zero-cycle latency). They are forced to 0 when issue_valid = 0.
- Load-use hazard: the youngest match for either source is an entry with is_load = 1 at stage k < LOAD_STAGE.
  - While a hazard exists: issue_ready = 0 and a bubble enters e[1]. The selects still reflect the youngest match but are don't-care to consumers.
  - No hazard: issue_ready = 1, including when issue_valid = 0.
  - A stall lasts LOAD_STAGE-k cycles, after which the load sits at LOAD_STAGE and is forwarded.
- stall_count increments when issue_valid & !issue_ready & !flush, and saturates at all-ones.
- flush: next cycle all e[k].valid = 0. issue_ready is not forced during flush, but the presented instruction is not recorded. flush does not clear stall_count.
- Reset (rst_n = 0 at an edge), including mid-stall: all entries invalid, stall_count = 0. Reset has priority over flush and issue.
- Combinational outputs settle to their defaults once the tracker is empty: issue_ready = 1, fwd1_sel = fwd2_sel = 0.
- A self-write (destination == source) uses older producers only; the presented instruction never forwards to itself.

Decomposition:
- defines.v additions: `FWD_SEL_RF (0), plus opcode-class usage macros if they are missing. No other typedefs are needed; the `OPCODE_* and instruction macros already exist.
- Sub-module operand_usage_decode: opcode in; use1, use2 and is_load out. It is combinational and reused by the decode stage.
- Tracker and hazard logic stay in the top module.

Test Plan:
1. Reset with STAGES=3, LOAD_STAGE=2. Issue ADD dest=1, then ADD src1=1 the next cycle -> fwd1_sel=1, fwd2_sel=0, issue_ready=1.
2. ADD dest=1, then NOP, then SUB src2=1 -> fwd2_sel=2. Same case with ADD write_en=0 -> fwd2_sel=0.
3. ADD dest=3 (cycle 0) and AND dest=3 (cycle 1); at cycle 2 issue XOR src1=3, src2=3 -> both selects = 1 (youngest wins). SHIFTL with src2=3 -> fwd2_sel=0 (source unused).
4. LOAD dest=2, then ADD src2=2 -> issue_ready=0 for exactly one cycle and stall_count 0->1. The next cycle: issue_ready=1, fwd2_sel=2. LOAD_STAGE=3 variant -> a 2-cycle stall, then fwd2_sel=3.
5. ADD dest=4, then flush, then ADD src1=4 -> fwd1_sel=0. Reset asserted mid-stall (after LOAD/ADD as in 4) -> next cycle issue_ready=1, stall_count=0.
6. Hold a load-use stall with CNT_W=2 for 5 cycles (long-latency LOAD re-issued) -> stall_count saturates at 3.

Source files
------------

// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared opcode encodings, select constants and opcode-class helpers
// for the operand-forwarding and hazard logic.
package forwarding_hazard_unit_pkg;

   localparam int FWD_SEL_RF = 0;

   localparam logic [6:0] OPCODE_NOP      = 7'd0;
   localparam logic [6:0] OPCODE_ADD      = 7'd1;
   localparam logic [6:0] OPCODE_ADDF     = 7'd2;
   localparam logic [6:0] OPCODE_SUB      = 7'd3;
   localparam logic [6:0] OPCODE_SUBF     = 7'd4;
   localparam logic [6:0] OPCODE_AND      = 7'd5;
   localparam logic [6:0] OPCODE_OR       = 7'd6;
   localparam logic [6:0] OPCODE_XOR      = 7'd7;
   localparam logic [6:0] OPCODE_NAND     = 7'd8;
   localparam logic [6:0] OPCODE_NOR      = 7'd9;
   localparam logic [6:0] OPCODE_NXOR     = 7'd10;
   localparam logic [6:0] OPCODE_SHIFTR   = 7'd11;
   localparam logic [6:0] OPCODE_SHIFTRA  = 7'd12;
   localparam logic [6:0] OPCODE_SHIFTL   = 7'd13;
   localparam logic [6:0] OPCODE_LOAD     = 7'd14;
   localparam logic [6:0] OPCODE_LOADC    = 7'd15;
   localparam logic [6:0] OPCODE_STORE    = 7'd16;
   localparam logic [6:0] OPCODE_JMP      = 7'd17;
   localparam logic [6:0] OPCODE_JMPR     = 7'd18;
   localparam logic [6:0] OPCODE_JMPCOND  = 7'd19;
   localparam logic [6:0] OPCODE_JMPRCOND = 7'd20;

   function automatic logic is_arith(input logic [6:0] op);
      return op inside {OPCODE_ADD, OPCODE_ADDF,
                        OPCODE_SUB, OPCODE_SUBF};
   endfunction

   function automatic logic is_logic(input logic [6:0] op);
      return op inside {OPCODE_AND, OPCODE_OR, OPCODE_XOR,
                        OPCODE_NAND, OPCODE_NOR, OPCODE_NXOR};
   endfunction

   function automatic logic is_shift(input logic [6:0] op);
      return op inside {OPCODE_SHIFTR, OPCODE_SHIFTRA,
                        OPCODE_SHIFTL};
   endfunction

endpackage

// File: rtl/forwarding_hazard_unit_usage.sv
// Combinational opcode decode: which source operands an
// instruction reads, and whether it is a memory load.
module operand_usage_decode
   import forwarding_hazard_unit_pkg::*;
(
   input  logic [6:0] opcode,
   output logic       use1,
   output logic       use2,
   output logic       is_load
);

   always_comb begin
      use1    = 1'b0;
      use2    = 1'b0;
      is_load = 1'b0;
      unique case (1'b1)
         is_arith(opcode),
         is_logic(opcode): begin
            use1 = 1'b1;
            use2 = 1'b1;
         end
         is_shift(opcode):             use1 = 1'b1;
         (opcode == OPCODE_LOADC):     use1 = 1'b1;
         (opcode == OPCODE_STORE): begin
            use1 = 1'b1;
            use2 = 1'b1;
         end
         (opcode == OPCODE_JMPCOND): begin
            use1 = 1'b1;
            use2 = 1'b1;
         end
         (opcode == OPCODE_JMPRCOND):  use1 = 1'b1;
         (opcode == OPCODE_LOAD): begin
            use2    = 1'b1;
            is_load = 1'b1;
         end
         (opcode == OPCODE_JMP):       use2 = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Tracks in-flight writers, selects forwarding sources per operand
// and stalls issue on load-use hazards.
module forwarding_hazard_unit
   import forwarding_hazard_unit_pkg::*;
#(
   parameter int REG_ADDR_W = 3,
   parameter int STAGES     = 3,
   parameter int LOAD_STAGE = 2,
   parameter int CNT_W      = 16,
   localparam int SEL_W     = $clog2(STAGES + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  issue_valid,
   output logic                  issue_ready,
   input  logic [6:0]            opcode,
   input  logic [REG_ADDR_W-1:0] source_1,
   input  logic [REG_ADDR_W-1:0] source_2,
   input  logic [REG_ADDR_W-1:0] destination,
   input  logic                  write_en,
   output logic [SEL_W-1:0]      fwd1_sel,
   output logic [SEL_W-1:0]      fwd2_sel,
   output logic [CNT_W-1:0]      stall_count
);

   logic [STAGES:1]       e_valid;
   logic [STAGES:1]       e_wr;
   logic [STAGES:1]       e_load;
   logic [REG_ADDR_W-1:0] e_dest [1:STAGES];

   logic             use1;
   logic             use2;
   logic             is_load;
   logic [SEL_W-1:0] sel1;
   logic [SEL_W-1:0] sel2;
   logic             ld1;
   logic             ld2;
   logic             hazard;
   logic             accept;

   operand_usage_decode u_usage (
      .opcode  (opcode),
      .use1    (use1),
      .use2    (use2),
      .is_load (is_load)
   );

   // Walk oldest to youngest so the youngest match is the last write.
   always_comb begin
      sel1 = SEL_W'(FWD_SEL_RF);
      sel2 = SEL_W'(FWD_SEL_RF);
      ld1  = 1'b0;
      ld2  = 1'b0;
      for (int k = STAGES; k >= 1; k--) begin
         if (use1 && e_valid[k] && e_wr[k] &&
             e_dest[k] == source_1) begin
            sel1 = SEL_W'(k);
            ld1  = e_load[k] && (k < LOAD_STAGE);
         end
         if (use2 && e_valid[k] && e_wr[k] &&
             e_dest[k] == source_2) begin
            sel2 = SEL_W'(k);
            ld2  = e_load[k] && (k < LOAD_STAGE);
         end
      end
   end

   assign hazard      = issue_valid && (ld1 || ld2);
   assign issue_ready = !hazard;
   assign accept      = issue_valid && issue_ready && !flush;
   assign fwd1_sel    = issue_valid ? sel1 : SEL_W'(FWD_SEL_RF);
   assign fwd2_sel    = issue_valid ? sel2 : SEL_W'(FWD_SEL_RF);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         e_valid     <= '0;
         stall_count <= '0;
      end else begin
         e_valid[1] <= accept;
         for (int k = 2; k <= STAGES; k++)
            e_valid[k] <= e_valid[k-1] && !flush;
         if (hazard && !flush && stall_count != '1)
            stall_count <= stall_count + 1'b1;
      end
   end

   // Payload only matters where the matching valid bit is set.
   always_ff @(posedge clk) begin
      e_dest[1] <= destination;
      e_wr[1]   <= write_en;
      e_load[1] <= is_load;
      for (int k = 2; k <= STAGES; k++) begin
         e_dest[k] <= e_dest[k-1];
         e_wr[k]   <= e_wr[k-1];
         e_load[k] <= e_load[k-1];
      end
   end

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Scoreboard bench: directed cases plus random issue streams
// checked against a history-queue reference model.
module tb_forwarding_hazard_unit;
   import forwarding_hazard_unit_pkg::*;

   localparam int S    = 4;
   localparam int LS   = 3;
   localparam int CW   = 3;
   localparam int SW   = $clog2(S + 1);
   localparam int MAXC = (1 << CW) - 1;

   typedef struct {
      bit       v;
      bit       wr;
      bit       ld;
      bit [2:0] dest;
   } ent_t;

   typedef struct {
      bit          rdy;
      int          f1;
      int          f2;
      int          cnt;
      int          id;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          issue_valid = 1'b0;
   logic          issue_ready;
   logic [6:0]    opcode = OPCODE_NOP;
   logic [2:0]    source_1 = '0;
   logic [2:0]    source_2 = '0;
   logic [2:0]    destination = '0;
   logic          write_en = 1'b0;
   logic [SW-1:0] fwd1_sel;
   logic [SW-1:0] fwd2_sel;
   logic [CW-1:0] stall_count;

   ent_t hist[$];
   exp_t exp_q[$];
   int   mcnt = 0;
   int   compared = 0;
   int   mismatched = 0;
   int   step_id = 0;
   bit   last_stall = 0;
   bit   saw_sat = 0;

   forwarding_hazard_unit #(
      .REG_ADDR_W (3),
      .STAGES     (S),
      .LOAD_STAGE (LS),
      .CNT_W      (CW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .opcode      (opcode),
      .source_1    (source_1),
      .source_2    (source_2),
      .destination (destination),
      .write_en    (write_en),
      .fwd1_sel    (fwd1_sel),
      .fwd2_sel    (fwd2_sel),
      .stall_count (stall_count)
   );

   always #5 clk = ~clk;

   function automatic void model_use(input logic [6:0] op,
                                     output bit u1,
                                     output bit u2,
                                     output bit ld);
      u1 = op inside {OPCODE_ADD, OPCODE_ADDF, OPCODE_SUB,
                      OPCODE_SUBF, OPCODE_AND, OPCODE_OR,
                      OPCODE_XOR, OPCODE_NAND, OPCODE_NOR,
                      OPCODE_NXOR, OPCODE_SHIFTR,
                      OPCODE_SHIFTRA, OPCODE_SHIFTL,
                      OPCODE_LOADC, OPCODE_STORE,
                      OPCODE_JMPCOND, OPCODE_JMPRCOND};
      u2 = op inside {OPCODE_ADD, OPCODE_ADDF, OPCODE_SUB,
                      OPCODE_SUBF, OPCODE_AND, OPCODE_OR,
                      OPCODE_XOR, OPCODE_NAND, OPCODE_NOR,
                      OPCODE_NXOR, OPCODE_LOAD, OPCODE_STORE,
                      OPCODE_JMP, OPCODE_JMPCOND};
      ld = (op == OPCODE_LOAD);
   endfunction

   function automatic int youngest(input bit u,
                                   input bit [2:0] src);
      for (int k = 1; k <= S; k++)
         if (u && hist[k-1].v && hist[k-1].wr &&
             hist[k-1].dest == src)
            return k;
      return 0;
   endfunction

   function automatic bit load_use(input int k);
      return k != 0 && hist[k-1].ld && k < LS;
   endfunction

   task automatic clear_model();
      hist.delete();
      for (int i = 0; i < S; i++)
         hist.push_back('{v: 0, wr: 0, ld: 0, dest: 0});
      mcnt = 0;
   endtask

   task automatic step(input bit v, input logic [6:0] op,
                       input bit [2:0] s1, input bit [2:0] s2,
                       input bit [2:0] d, input bit we,
                       input bit fl, input bit rs);
      exp_t e;
      ent_t n;
      bit   u1, u2, ld, hz;
      int   m1, m2;
      @(negedge clk);
      issue_valid = v;
      opcode      = op;
      source_1    = s1;
      source_2    = s2;
      destination = d;
      write_en    = we;
      flush       = fl;
      rst_n       = !rs;
      model_use(op, u1, u2, ld);
      m1 = youngest(u1, s1);
      m2 = youngest(u2, s2);
      hz = v && (load_use(m1) || load_use(m2));
      e.rdy = !hz;
      e.f1  = v ? m1 : 0;
      e.f2  = v ? m2 : 0;
      e.cnt = mcnt;
      e.id  = step_id++;
      exp_q.push_back(e);
      if (mcnt == MAXC) saw_sat = 1;
      if (rs) begin
         clear_model();
      end else begin
         if (hz && !fl && mcnt < MAXC) mcnt++;
         n = '{v: v && !hz && !fl, wr: we, ld: ld, dest: d};
         hist.push_front(n);
         void'(hist.pop_back());
         if (fl)
            foreach (hist[i]) hist[i].v = 0;
      end
      last_stall = hz;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compared++;
            if (issue_ready !== e.rdy ||
                fwd1_sel !== SW'(e.f1) ||
                fwd2_sel !== SW'(e.f2) ||
                stall_count !== CW'(e.cnt)) begin
               mismatched++;
               $display("FAIL step%0d got rdy=%b f1=%0d f2=%0d cnt=%0d want rdy=%b f1=%0d f2=%0d cnt=%0d",
                        e.id, issue_ready, fwd1_sel, fwd2_sel,
                        stall_count, e.rdy, e.f1, e.f2, e.cnt);
            end
         end
      end
   end

   logic [6:0] ops[22];
   initial begin : driver
      bit [2:0] h1, h2, hd;
      bit       hw;
      logic [6:0] hop;
      ops = '{OPCODE_NOP, OPCODE_ADD, OPCODE_ADDF, OPCODE_SUB,
              OPCODE_SUBF, OPCODE_AND, OPCODE_OR, OPCODE_XOR,
              OPCODE_NAND, OPCODE_NOR, OPCODE_NXOR,
              OPCODE_SHIFTR, OPCODE_SHIFTRA, OPCODE_SHIFTL,
              OPCODE_LOAD, OPCODE_LOADC, OPCODE_STORE,
              OPCODE_JMP, OPCODE_JMPR, OPCODE_JMPCOND,
              OPCODE_JMPRCOND, 7'd99};
      clear_model();
      repeat (2) @(posedge clk);
      // Directed: reset, forward, youngest wins, unused source.
      step(0, OPCODE_NOP, 0, 0, 0, 0, 0, 1);
      step(1, OPCODE_ADD, 0, 0, 1, 1, 0, 0);
      step(1, OPCODE_ADD, 1, 0, 2, 1, 0, 0);
      step(1, OPCODE_ADD, 0, 0, 3, 0, 0, 0);
      step(1, OPCODE_SUB, 0, 1, 4, 1, 0, 0);
      step(1, OPCODE_ADD, 0, 0, 3, 1, 0, 0);
      step(1, OPCODE_AND, 0, 0, 3, 1, 0, 0);
      step(1, OPCODE_XOR, 3, 3, 5, 1, 0, 0);
      step(1, OPCODE_SHIFTL, 0, 3, 6, 1, 0, 0);
      // Load-use: multi-cycle stall with the consumer held.
      step(1, OPCODE_LOAD, 0, 0, 2, 1, 0, 0);
      repeat (4) step(1, OPCODE_ADD, 0, 2, 7, 1, 0, 0);
      // Flush hides a producer; self-write uses older producer.
      step(1, OPCODE_ADD, 0, 0, 4, 1, 0, 0);
      step(0, OPCODE_NOP, 0, 0, 0, 0, 1, 0);
      step(1, OPCODE_ADD, 4, 0, 5, 1, 0, 0);
      step(1, OPCODE_ADD, 5, 0, 5, 1, 0, 0);
      step(0, OPCODE_NOP, 0, 0, 0, 0, 0, 0);
      // Reset mid-stall.
      step(1, OPCODE_LOAD, 0, 0, 6, 1, 0, 0);
      step(1, OPCODE_STORE, 6, 6, 0, 0, 0, 1);
      step(1, OPCODE_STORE, 6, 6, 0, 0, 0, 0);
      // Long stall drives the counter into saturation.
      for (int i = 0; i < 4; i++) begin
         step(1, OPCODE_LOAD, 0, 0, 1, 1, 0, 0);
         repeat (2) step(1, OPCODE_ADD, 1, 0, 2, 1, 0, 0);
      end
      step(1, OPCODE_LOAD, 0, 0, 1, 1, 0, 0);
      step(1, OPCODE_ADD, 1, 0, 2, 1, 0, 0);
      step(0, OPCODE_NOP, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         if (!(last_stall && $urandom_range(0, 4) != 0)) begin
            hop = ops[$urandom_range(0, 21)];
            h1  = 3'($urandom_range(0, 7));
            h2  = 3'($urandom_range(0, 7));
            hd  = 3'($urandom_range(0, 7));
            hw  = $urandom_range(0, 4) != 0;
         end
         step($urandom_range(0, 6) != 0, hop, h1, h2, hd, hw,
              $urandom_range(0, 19) == 0,
              $urandom_range(0, 299) == 0);
      end
      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL drain got %0d pending want 0",
                  exp_q.size());
      end
      if (!saw_sat) begin
         mismatched++;
         $display("FAIL saturation got unreached want reached");
      end
      compared++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
